// File: rtl/axi_lite_pkg.sv
// ============================================================================
// Module      : axi_lite_pkg
// Description : Shared definitions for the command-driven AXI4-Lite master:
//               FSM state encoding, AXI response codes, address LSB index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_lite_pkg;

    // Master sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Registers are 32-bit, so byte address bits [1:0] select a byte lane
    localparam int ADDR_LSB = 2;

endpackage

`default_nettype wire

// File: rtl/axi4_lite_m_cmd.sv
// ============================================================================
// Module      : axi4_lite_m_cmd
// Description : Command-driven AXI4-Lite master. Accepts one read or write
//               command at a time, runs a single-beat AXI4-Lite transaction
//               and returns read data / response code on a valid/ready
//               response channel. One transaction outstanding at most.
// Optional    : `define TIMEOUT_EN adds a watchdog; after C_TIMEOUT_CYCLES
//               clocks in a waiting state the transaction is abandoned and a
//               SLVERR response is returned.
// Ports       : M_AXI_ACLK / M_AXI_ARESET (async, active-high)
//               i_cmd_*  : command channel (valid/ready, rw, addr, wdata, wstrb)
//               o_rsp_*  : response channel (valid/ready, rdata, resp)
//               o_busy   : transaction in progress
//               M_AXI_*  : AXI4-Lite master interface
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi4_lite_m_cmd
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 9,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    // command channel
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_rw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
    // response channel
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                      o_rsp_resp,
    output logic                            o_busy,
    // AXI4-Lite write address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    // AXI4-Lite write data
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    // AXI4-Lite write response
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    // AXI4-Lite read address
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    // AXI4-Lite read data
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    state_e          state_q,   state_d;
    logic [AW-1:0]   awaddr_q,  awaddr_d;
    logic [AW-1:0]   araddr_q,  araddr_d;
    logic [DW-1:0]   wdata_q,   wdata_d;
    logic [SW-1:0]   wstrb_q,   wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q,  wvalid_d;
    logic            bready_q,  bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q,  rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rdata_q,   rdata_d;
    logic [1:0]      resp_q,    resp_d;

    // A channel counts as done once its VALID is already low or handshakes now
    logic            aw_done, w_done;

`ifdef TIMEOUT_EN
    localparam int CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic             timeout;
`endif

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= ST_IDLE;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
`ifdef TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
`ifdef TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;

        aw_done = !awvalid_q || M_AXI_AWREADY;
        w_done  = !wvalid_q  || M_AXI_WREADY;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    if (i_cmd_rw) begin
                        araddr_d  = i_cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end else begin
                        awaddr_d  = i_cmd_addr;
                        wdata_d   = i_cmd_wdata;
                        wstrb_d   = i_cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end
                end
            end
            ST_WR: begin
                // AW and W complete independently, in either order
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q  && M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    resp_d      = M_AXI_BRESP;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rdata_d     = M_AXI_RDATA;
                    resp_d      = M_AXI_RRESP;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef TIMEOUT_EN
        // Watchdog overrides any handshake landing in the expiry cycle; the
        // slave is left mid-transaction on purpose to recover the master.
        waiting = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                  (state_q == ST_RD_ADDR) || (state_q == ST_RD_DATA);
        timeout = waiting && (cnt_q == CNT_W'(C_TIMEOUT_CYCLES - 1));
        if (timeout) begin
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            bready_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            resp_d      = RESP_SLVERR;
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
        end
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (waiting) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
`endif
    end

    assign o_cmd_ready   = (state_q == ST_IDLE);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;

    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_m_cmd.sv
// ============================================================================
// Module      : tb_axi4_lite_m_cmd
// Description : Self-checking bench for axi4_lite_m_cmd with a small
//               AXI4-Lite slave model (per-channel ready latency, 128-word
//               register file, optional B stall and read error).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi4_lite_m_cmd;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [8:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [8:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi4_lite_m_cmd #(
        .C_M_AXI_DATA_WIDTH (32),
        .C_M_AXI_ADDR_WIDTH (9),
        .C_TIMEOUT_CYCLES   (16)
    ) u_dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESET  (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_rw      (cmd_rw),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .i_cmd_wstrb   (cmd_wstrb),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_resp    (rsp_resp),
        .o_busy        (busy),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    // ------------------------------------------------------------------------
    // Slave model
    // ------------------------------------------------------------------------
    logic [31:0] mem [0:127];
    int          aw_lat, w_lat, ar_lat;
    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_hs_n, w_hs_n, b_hs_n;
    logic        b_hold, r_err;
    logic        aw_got, w_got;
    logic [8:0]  aw_a, ar_a;
    logic [31:0] w_d;
    logic [3:0]  w_s;
    logic        aw_hs, w_hs, ar_hs;

    assign awready = awvalid && (aw_cnt >= aw_lat);
    assign wready  = wvalid  && (w_cnt  >= w_lat);
    assign arready = arvalid && (ar_cnt >= ar_lat);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid  && wready;
    assign ar_hs   = arvalid && arready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            aw_a <= '0; w_d <= '0; w_s <= '0; ar_a <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid  && !wready)  ? w_cnt + 1  : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (aw_hs) begin aw_hs_n <= aw_hs_n + 1; aw_a <= awaddr; end
            if (w_hs)  begin w_hs_n <= w_hs_n + 1; w_d <= wdata; w_s <= wstrb; end
            if ((aw_got || aw_hs) && (w_got || w_hs) && !bvalid && !b_hold) begin
                for (int b = 0; b < 4; b++) begin
                    if ((w_hs ? wstrb[b] : w_s[b]))
                        mem[(aw_hs ? awaddr[8:2] : aw_a[8:2])][8*b +: 8] <=
                            (w_hs ? wdata[8*b +: 8] : w_d[8*b +: 8]);
                end
                bvalid <= 1'b1;
                bresp  <= 2'b00;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_hs_n <= b_hs_n + 1;
            end
            if (ar_hs) begin
                ar_a   <= araddr;
                rvalid <= 1'b1;
                rdata  <= mem[araddr[8:2]];
                rresp  <= r_err ? 2'b10 : 2'b00;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a command at a negedge; returns #1 after the accepting edge and
    // scrambles the command inputs so later changes are shown to be ignored.
    task automatic send_cmd(input logic rw, input logic [8:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_addr = 9'h1FC; cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'h0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 60);
        if (!rsp_valid) chk("rsp_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic consume;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    int n, b0;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[65] = 32'h12345678;
        mem[8]  = 32'h11223344;
        aw_lat = 0; w_lat = 0; ar_lat = 0;
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0;
        b_hold = 1'b0; r_err = 1'b0;
        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        rst = 1'b1;

        // Reset state
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_valids",    {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
        chk("rst_rsp",       rsp_rdata | {30'd0, rsp_resp}, 32'd0);
        chk("rst_addr_data", {14'd0, awaddr, araddr} | wdata | {28'd0, wstrb}, 32'd0);
        chk("rst_prot",      {26'd0, awprot, arprot}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Write 0x010 against zero-wait slave: cycle-exact sequence
        send_cmd(1'b0, 9'h010, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("wr_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        chk("wr_c1_awaddr", {23'd0, awaddr}, 32'h010);
        chk("wr_c1_wdata",  wdata, 32'hDEADBEEF);
        chk("wr_c1_rspv",   {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("wr_c2_state",  {29'd0, awvalid, wvalid, bready}, 32'd1);
        chk("wr_c2_rspv",   {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("wr_c3_rspv",   {31'd0, rsp_valid}, 32'd1);
        chk("wr_c3_resp",   {30'd0, rsp_resp}, 32'd0);
        chk("wr_c3_rdata",  rsp_rdata, 32'd0);
        chk("wr_c3_bready", {31'd0, bready}, 32'd0);
        chk("wr_hs_counts", {aw_hs_n[7:0], w_hs_n[7:0], b_hs_n[7:0], 8'd0}, 32'h01010100);
        consume();

        // Read 0x104 (register 65)
        send_cmd(1'b1, 9'h104, 32'h0, 4'h0);
        wait_rsp(n);
        chk("rd_latency", n, 32'd3);
        chk("rd_araddr",  {23'd0, ar_a}, 32'h104);
        chk("rd_rdata",   rsp_rdata, 32'h12345678);
        chk("rd_resp",    {30'd0, rsp_resp}, 32'd0);
        consume();

        // WREADY three cycles ahead of AWREADY, partial strobe into reg 8
        aw_lat = 3; w_lat = 0;
        b0 = b_hs_n;
        send_cmd(1'b0, 9'h020, 32'hAABBCCDD, 4'h5);
        @(negedge clk);
        chk("ooo_c1_valids", {30'd0, awvalid, wvalid}, 32'd3);
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            chk("ooo_aw_only",   {30'd0, awvalid, wvalid}, 32'd2);
            chk("ooo_awaddr",    {23'd0, awaddr}, 32'h020);
        end
        wait_rsp(n);
        chk("ooo_b_count", b_hs_n - b0, 32'd1);
        chk("ooo_resp",    {30'd0, rsp_resp}, 32'd0);
        consume();
        aw_lat = 0;

        send_cmd(1'b1, 9'h020, 32'h0, 4'h0);
        wait_rsp(n);
        chk("strb_rdata", rsp_rdata, 32'h11BB33DD);
        consume();

        // Slave error on read is passed through
        r_err = 1'b1;
        send_cmd(1'b1, 9'h104, 32'h0, 4'h0);
        wait_rsp(n);
        chk("slverr_resp",  {30'd0, rsp_resp}, 32'd2);
        chk("slverr_rdata", rsp_rdata, 32'h12345678);
        consume();
        r_err = 1'b0;

        // Response held for 5 cycles, then back-to-back command
        send_cmd(1'b1, 9'h010, 32'h0, 4'h0);
        wait_rsp(n);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_rspv",  {31'd0, rsp_valid}, 32'd1);
            chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("hold_cmdrdy", {31'd0, cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 9'h104;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("b2b_idle_ready", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("b2b_accepted", {30'd0, busy, cmd_ready}, 32'd2);
        wait_rsp(n);
        chk("b2b_latency", n, 32'd3);
        chk("b2b_rdata",   rsp_rdata, 32'h12345678);
        consume();

`ifdef TIMEOUT_EN
        // ARREADY stuck low: watchdog abandons the read after 16 cycles
        ar_lat = 1000;
        send_cmd(1'b1, 9'h104, 32'h0, 4'h0);
        n = 0;
        do begin
            @(negedge clk);
            if (arvalid) n++;
        end while (arvalid && n < 40);
        chk("to_arvalid_cycles", n, 32'd16);
        chk("to_rspv",  {31'd0, rsp_valid}, 32'd1);
        chk("to_resp",  {30'd0, rsp_resp}, 32'd2);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_outs",  {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
        consume();
        chk("to_idle",  {31'd0, cmd_ready}, 32'd1);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        ar_lat = 0;
`endif

        // Reset during WR_RESP
        b_hold = 1'b1;
        send_cmd(1'b0, 9'h030, 32'hCAFEF00D, 4'hF);
        repeat (2) @(negedge clk);
        chk("rstmid_in_wr_resp", {30'd0, bready, busy}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_outs",  {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
        chk("rstmid_busy",  {30'd0, busy, cmd_ready}, 32'd1);
        chk("rstmid_data",  {14'd0, awaddr, araddr} | wdata | {28'd0, wstrb}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b_hold = 1'b0;
        @(negedge clk);
        chk("rstmid_ready_after", {31'd0, cmd_ready}, 32'd1);
        send_cmd(1'b1, 9'h104, 32'h0, 4'h0);
        wait_rsp(n);
        chk("rstmid_recover_rdata", rsp_rdata, 32'h12345678);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_time_limit got=%0d exp=%0d", 1, 0);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/axi4_lite_m_cmd.md
Name: axi4_lite_m_cmd

Overview:
- Command-driven AXI4-Lite master: the initiator end of the register interface our AXI4-Lite slaves answer.
- Accepts one read or write command at a time from local logic (DSP-side sequencer, SFP parameter loader) and runs one single-beat AXI4-Lite transaction.
- Returns read data and response code through a valid/ready response channel.
- Strictly one transaction outstanding; no bursts.

Parameters:
C_M_AXI_DATA_WIDTH, 32, data bus width (32 only supported)
C_M_AXI_ADDR_WIDTH, 9, address width (byte address, 4-byte aligned registers)
C_TIMEOUT_CYCLES, 1024, watchdog limit in clocks (used only with TIMEOUT_EN)

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESET  in  1  asynchronous reset, active-high
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  block idle, command accepted when valid&ready
i_cmd_rw  in  1  0 write, 1 read
i_cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
i_cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
i_cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte strobes
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  response consumed
o_rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data (0 for writes)
o_rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
o_busy  out  1  state != IDLE
M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master directions and widths; AWPROT=ARPROT=3'b000.

Behaviour:
- Reset (async assert, sync release): state IDLE; all VALID/READY outputs 0; o_rsp_valid 0; o_rsp_rdata 0; o_rsp_resp 0; AWADDR/ARADDR/WDATA/WSTRB 0; o_busy 0.
- o_cmd_ready = (state==IDLE), combinational from the registered state.
- Command fields are registered on acceptance; later changes to i_cmd_* are ignored.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE -> WR (write): AWVALID and WVALID both asserted the next cycle.
  - Each VALID drops independently on its own handshake (xVALID&xREADY).
  - A ready signal seen in the same cycle as the other channel's handshake is legal.
  - When both handshakes are done, BREADY=1 and the FSM moves to WR_RESP. The last handshake cycle moves directly to WR_RESP.
- WR_RESP: on BVALID&BREADY, latch BRESP, o_rsp_rdata=0, BREADY=0, go to RSP.
- IDLE -> RD_ADDR (read): ARVALID=1 until ARREADY, then RREADY=1 and go to RD_DATA.
- RD_DATA: on RVALID&RREADY, latch RDATA/RRESP, RREADY=0, go to RSP.
- RSP: o_rsp_valid=1 and response held stable until i_rsp_ready, then IDLE.
- Latencies:
  - Minimum command-accept to o_rsp_valid: 3 cycles against a zero-wait slave.
  - A new command can be accepted the cycle after the response handshake.
- VALID is never deasserted before its handshake, and address/data never change while VALID is high (AXI rule).
- Reset mid-transaction aborts immediately; the slave must be reset by the same reset.

Optional Feature:
TIMEOUT_EN
- Defined: a cycle counter clears on each state entry and counts in WR, WR_RESP, RD_ADDR and RD_DATA.
  - When the count reaches C_TIMEOUT_CYCLES-1: all AXI VALID/READY outputs are forced 0, o_rsp_resp=2'b10, o_rsp_rdata=0, and the FSM goes to RSP.
  - The abandoned transaction is a deliberate protocol violation, accepted for fault recovery.
- Undefined: no counter; the block waits forever.

Decomposition:
- Shared package axi_lite_pkg holds:
  - FSM state enumeration
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - ADDR_LSB=2
- No sub-module. The watchdog counter lives inline under the macro.

Test Plan:
- Write addr 0x010, data 0xDEADBEEF, strb 0xF, zero-wait slave -> single AW and W handshake, BRESP 00, o_rsp_valid on the 3rd cycle after accept, o_rsp_rdata 0.
- Read addr 0x104 against slave register 65 holding 0x12345678 -> ARADDR 0x104, o_rsp_rdata 0x12345678, o_rsp_resp 00.
- Slave gives WREADY 3 cycles before AWREADY -> WVALID drops first, AWADDR stable until its handshake, exactly one B handshake.
- i_rsp_ready held low 5 cycles -> o_rsp_valid and data stable, o_cmd_ready 0 throughout; a new command is accepted the cycle after ready.
- TIMEOUT_EN with C_TIMEOUT_CYCLES=16 and ARREADY stuck low -> ARVALID drops after 16 cycles, o_rsp_resp 10, FSM returns to IDLE after the response handshake.
- Assert M_AXI_ARESET during WR_RESP -> all outputs take reset values immediately, o_cmd_ready 1 after release.
